ee_merge_fifo: RTL and testbench

Parametrised multi-channel end-event merger for the gigafitter mezzanine input path. It accepts NCH independent strobed word streams, one from each upstream link. Each stream is buffered in its own FIFO, and the block emits a single merged stream per event: channel 0's words, then channel 1's, and so on. Each merged event ends with exactly one end-event (EE) word, whose tags are cross-checked across channels. It sits between the link receivers and the fitter core, and drives per-channel hold back to the sources.

---
 rtl/ee_merge_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_ee_merge_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ee_merge_fifo.sv
// ee_merge_fifo
// Merges NCH strobed word streams into one stream per event. Each channel has
// its own FIFO. For every event the block emits channel 0's data words, then
// channel 1's, and so on, followed by one merged end-event (EE) word. The
// merged EE word carries channel 0's tag and a flag that is set when any
// channel's tag differs from it.
//
// Ports:
//   WRITECLK    clock; all state updates on the rising edge
//   RESET_N     asynchronous active-low reset
//   DS_N        per-channel data strobe, active low
//   DATA_IN     channel c word at [c*DW +: DW]; bit DW-1 = EE, bit DW-2 = EP
//   W_HOLD      per-channel registered hold request (occupancy >= DEPTH-HOLD_MARGIN)
//   DOUT        merged output word
//   DOUT_VALID  DOUT holds a valid word
//   DOUT_READY  downstream accepts DOUT when VALID & READY
//   TAG_ERR     one-cycle pulse when a merged EE carrying a mismatch appears
//   ERR_CNT     saturating count of mismatched events
//   OVERFLOW    sticky per-channel flag: a word was dropped on a full FIFO
`timescale 1ns/1ps
module ee_merge_fifo #(
  parameter int NCH         = 2,
  parameter int DW          = 23,
  parameter int DEPTH       = 64,
  parameter int HOLD_MARGIN = 8,
  parameter int TAGW        = 8
) (
  input  logic              WRITECLK,
  input  logic              RESET_N,
  input  logic [NCH-1:0]    DS_N,
  input  logic [NCH*DW-1:0] DATA_IN,
  output logic [NCH-1:0]    W_HOLD,
  output logic [DW-1:0]     DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              TAG_ERR,
  output logic [15:0]       ERR_CNT,
  output logic [NCH-1:0]    OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HOLD_CNT = (AW+1)'(DEPTH - HOLD_MARGIN);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  typedef enum logic {S_SCAN, S_EMIT} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                tag_err_q, tag_err_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [NCH*TAGW-1:0] tag_q, tag_d;

  logic [NCH-1:0]      pop_vec;
  logic [NCH-1:0]      nonempty;
  logic [NCH*DW-1:0]   head_flat;
  logic [DW-1:0]       cur_head;
  logic                out_free;
  logic                mismatch;
  logic [DW-1:0]       merged_ee;

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs. Head word is read combinationally so that a word
  // written on edge k can be popped into DOUT on edge k+1.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DW-1:0] mem [DEPTH];
      logic [AW-1:0] wr_ptr_q;
      logic [AW-1:0] rd_ptr_q;
      logic [AW:0]   cnt_q;
      logic          hold_q;
      logic          ovf_q;
      logic          wr_req;
      logic          push_ok;

      assign wr_req  = ~DS_N[gi];
      // A full FIFO still accepts a word when it is popped on the same edge.
      assign push_ok = wr_req && ((cnt_q != FULL_CNT) || pop_vec[gi]);

      assign nonempty[gi]             = (cnt_q != '0);
      assign head_flat[gi*DW +: DW]   = mem[rd_ptr_q];
      assign W_HOLD[gi]               = hold_q;
      assign OVERFLOW[gi]             = ovf_q;

      always_ff @(posedge WRITECLK) begin
        if (push_ok) begin
          mem[wr_ptr_q] <= DATA_IN[gi*DW +: DW];
        end
      end

      always_ff @(posedge WRITECLK or negedge RESET_N) begin
        if (!RESET_N) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
          hold_q   <= 1'b0;
          ovf_q    <= 1'b0;
        end else begin
          if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
          end
          if (pop_vec[gi]) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
          case ({push_ok, pop_vec[gi]})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
          endcase
          // Registered from the current occupancy: rises one edge after the
          // threshold is reached.
          hold_q <= (cnt_q >= HOLD_CNT);
          if (wr_req && !push_ok) begin
            ovf_q <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Tag cross-check and merged EE word
  // ---------------------------------------------------------------------------
  always_comb begin
    mismatch = 1'b0;
    for (int c = 1; c < NCH; c++) begin
      if (tag_q[c*TAGW +: TAGW] != tag_q[TAGW-1:0]) begin
        mismatch = 1'b1;
      end
    end
  end

  always_comb begin
    merged_ee             = '0;
    merged_ee[DW-1]       = 1'b1;
    merged_ee[DW-2]       = 1'b1;
    merged_ee[DW-3]       = mismatch;
    merged_ee[TAGW-1:0]   = tag_q[TAGW-1:0];
  end

  // ---------------------------------------------------------------------------
  // Merge FSM
  // ---------------------------------------------------------------------------
  assign out_free = !dout_valid_q || DOUT_READY;
  assign cur_head = head_flat[int'(chan_q)*DW +: DW];

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    tag_err_d    = 1'b0;
    err_cnt_d    = err_cnt_q;
    tag_d        = tag_q;
    pop_vec      = '0;

    // Current word leaves (or nothing was held); valid drops unless reloaded.
    if (out_free) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      S_SCAN: begin
        if (out_free && nonempty[chan_q]) begin
          pop_vec[chan_q] = 1'b1;
          if (cur_head[DW-1]) begin
            tag_d[int'(chan_q)*TAGW +: TAGW] = cur_head[TAGW-1:0];
            if (chan_q == LAST_CH) begin
              state_d = S_EMIT;
              chan_d  = '0;
            end else begin
              chan_d = chan_q + 1'b1;
            end
          end else begin
            dout_d       = cur_head;
            dout_valid_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (out_free) begin
          dout_d       = merged_ee;
          dout_valid_d = 1'b1;
          tag_err_d    = mismatch;
          if (mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
          state_d = S_SCAN;
          chan_d  = '0;
        end
      end
      default: begin
        state_d = S_SCAN;
        chan_d  = '0;
      end
    endcase
  end

  always_ff @(posedge WRITECLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_SCAN;
      chan_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      tag_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      tag_err_q    <= tag_err_d;
      err_cnt_q    <= err_cnt_d;
      tag_q        <= tag_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign TAG_ERR    = tag_err_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_ee_merge_fifo.sv
// Testbench for ee_merge_fifo: directed scenarios plus randomized traffic,
// checked against an event-level merge model.
`timescale 1ns/1ps
module tb_ee_merge_fifo;
  localparam int NCH  = 2;
  localparam int DW   = 23;
  localparam int DEPTH = 16;
  localparam int HM   = 4;
  localparam int TAGW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    ds_n;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    w_hold;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic              rdy;
  logic              tag_err;
  logic [15:0]       err_cnt;
  logic [NCH-1:0]    overflow;

  always #5 clk = ~clk;

  ee_merge_fifo #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .HOLD_MARGIN(HM), .TAGW(TAGW)) dut (
    .WRITECLK(clk), .RESET_N(rst_n), .DS_N(ds_n), .DATA_IN(din),
    .W_HOLD(w_hold), .DOUT(dout), .DOUT_VALID(dout_valid), .DOUT_READY(rdy),
    .TAG_ERR(tag_err), .ERR_CNT(err_cnt), .OVERFLOW(overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus and reference model state ----------------
  logic [DW-1:0]   src_q [NCH][$];   // words waiting to be strobed
  logic [DW-1:0]   mq    [NCH][$];   // words delivered, not yet merged by model
  logic [DW-1:0]   exp_q [$];        // expected output stream
  logic [TAGW-1:0] m_tag [NCH];
  int              m_ch = 0;
  int              exp_err = 0;
  int              strobe_pct = 100;
  bit              rnd_ready = 1'b0;
  int              cyc = 0;
  int              last_xfer_cyc = 0;
  bit              new_word = 1'b1;
  bit              mon_en = 1'b0;
  logic [DW-1:0]   mon_front;

  // Event-level merge: walk channels in order, data words go straight out,
  // an EE records the tag and moves on; after the last channel the merged
  // EE word is produced.
  function automatic void model_run();
    logic [DW-1:0] w;
    bit mis;
    while (1) begin
      if (m_ch == NCH) begin
        mis = 1'b0;
        for (int c = 1; c < NCH; c++) if (m_tag[c] != m_tag[0]) mis = 1'b1;
        w = '0;
        w[DW-1] = 1'b1;
        w[DW-2] = 1'b1;
        w[DW-3] = mis;
        w[TAGW-1:0] = m_tag[0];
        exp_q.push_back(w);
        if (mis && exp_err < 65535) exp_err++;
        m_ch = 0;
      end else if (mq[m_ch].size() > 0) begin
        w = mq[m_ch].pop_front();
        if (w[DW-1]) begin
          m_tag[m_ch] = w[TAGW-1:0];
          m_ch++;
        end else begin
          exp_q.push_back(w);
        end
      end else begin
        break;
      end
    end
  endfunction

  function automatic void model_push(input int c, input logic [DW-1:0] w);
    mq[c].push_back(w);
    model_run();
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      src_q[c].delete();
      m_tag[c] = '0;
    end
    exp_q.delete();
    m_ch = 0;
    exp_err = 0;
  endfunction

  function automatic bit src_busy();
    bit b = 1'b0;
    for (int c = 0; c < NCH; c++) if (src_q[c].size() > 0) b = 1'b1;
    return b;
  endfunction

  // One cycle: drive strobes from the source queues (respecting W_HOLD),
  // optionally randomize READY, then advance past the rising edge.
  task automatic step();
    logic [DW-1:0] w;
    for (int c = 0; c < NCH; c++) begin
      if (src_q[c].size() > 0 && !w_hold[c] && ($urandom_range(0, 99) < strobe_pct)) begin
        w = src_q[c].pop_front();
        ds_n[c] = 1'b0;
        din[c*DW +: DW] = w;
        model_push(c, w);
      end else begin
        ds_n[c] = 1'b1;
      end
    end
    if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_one(input int c, input logic [DW-1:0] w, input bit to_model);
    ds_n = '1;
    ds_n[c] = 1'b0;
    din[c*DW +: DW] = w;
    if (to_model) model_push(c, w);
    @(posedge clk);
    #1;
    ds_n = '1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((src_busy() || exp_q.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (5) step();
  endtask

  task automatic load(input int c, input logic [DW-1:0] w);
    src_q[c].push_back(w);
  endtask

  // ---------------- output monitor ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      new_word = 1'b1;
    end else if (mon_en) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("dout_unexpected", 32'(dout_valid), 32'd0);
        end else begin
          mon_front = exp_q[0];
          chk("dout", 32'(dout), 32'(mon_front));
          chk("tag_err", 32'(tag_err),
              32'(new_word && mon_front[DW-1] && mon_front[DW-3]));
          if (rdy) begin
            void'(exp_q.pop_front());
            last_xfer_cyc = cyc;
            $display("xfer cyc=%0d dout=0x%06h tag_err=%0d", cyc, dout, tag_err);
          end
        end
      end else begin
        chk("tag_err_idle", 32'(tag_err), 32'd0);
      end
      new_word = !dout_valid || rdy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int start;
    logic [DW-1:0] w;
    logic [TAGW-1:0] base, tg;

    rst_n = 1'b0;
    ds_n  = '1;
    din   = '0;
    rdy   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout",     32'(dout),       32'd0);
    chk("rst_valid",    32'(dout_valid), 32'd0);
    chk("rst_hold",     32'(w_hold),     32'd0);
    chk("rst_tag_err",  32'(tag_err),    32'd0);
    chk("rst_err_cnt",  32'(err_cnt),    32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    rdy    = 1'b1;
    @(posedge clk);
    #1;

    // Basic merge
    load(0, 23'h00cc0c); load(0, 23'h0539da); load(0, 23'h600001);
    load(1, 23'h081a25); load(1, 23'h600001);
    drain("basic");
    chk("basic_err_cnt", 32'(err_cnt), 32'(exp_err));

    // Tag mismatch
    load(0, 23'h0cc6c6); load(0, 23'h600002);
    load(1, 23'h1132d6); load(1, 23'h600003);
    drain("mismatch");
    chk("mismatch_err_cnt", 32'(err_cnt), 32'(exp_err));

    // Back-to-back events, channel with EE only; 7 edges from first write
    // edge to the last merged EE (3 cycles for event 1, 4 for event 2).
    load(0, 23'h600001); load(0, 23'h15feed); load(0, 23'h600002);
    load(1, 23'h600001); load(1, 23'h600002);
    start = cyc + 1;
    drain("b2b");
    chk("b2b_latency", 32'(last_xfer_cyc - start), 32'd7);

    // Randomized traffic with random strobes and backpressure
    for (int e = 0; e < 30; e++) begin
      base = 8'($urandom);
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
          w = 23'($urandom);
          w[DW-1] = 1'b0;
          load(c, w);
        end
        tg = base;
        if ($urandom_range(0, 3) == 0) tg = base ^ 8'($urandom_range(1, 255));
        w = 23'($urandom);
        w[DW-1] = 1'b1;
        w[DW-2] = 1'b1;
        w[TAGW-1:0] = tg;
        load(c, w);
      end
    end
    strobe_pct = 60;
    rnd_ready  = 1'b1;
    drain("random");
    rnd_ready  = 1'b0;
    strobe_pct = 100;
    rdy = 1'b1;
    chk("random_err_cnt",  32'(err_cnt),  32'(exp_err));
    chk("random_overflow", 32'(overflow), 32'd0);

    // Backpressure, hold and overflow: one word parked in DOUT, then 17 more
    // into ch0; the FIFO takes 16 and drops the 17th.
    rdy = 1'b0;
    drive_one(0, 23'h0000aa, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_preload_valid", 32'(dout_valid), 32'd1);
    for (int i = 1; i <= 17; i++) begin
      drive_one(0, 23'(32'h010000 + i), (i <= 16));
      if (i == 12) chk("hold_at_threshold", 32'(w_hold[0]), 32'd0);
      if (i == 13) chk("hold_after_threshold", 32'(w_hold[0]), 32'd1);
    end
    chk("overflow_set", 32'(overflow), 32'd1);
    repeat (3) step();
    rdy = 1'b1;
    drain("bp");
    chk("hold_released", 32'(w_hold), 32'd0);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of an event
    rdy = 1'b0;
    drive_one(0, 23'h04b68c, 1'b1);
    @(posedge clk);
    #1;
    chk("midrst_pre_valid", 32'(dout_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_dout",     32'(dout),       32'd0);
    chk("midrst_valid",    32'(dout_valid), 32'd0);
    chk("midrst_err_cnt",  32'(err_cnt),    32'd0);
    chk("midrst_overflow", 32'(overflow),   32'd0);
    chk("midrst_hold",     32'(w_hold),     32'd0);
    chk("midrst_tag_err",  32'(tag_err),    32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy = 1'b1;
    load(0, 23'h287e23); load(0, 23'h600003);
    load(1, 23'h600003);
    drain("post_reset");
    chk("post_reset_err_cnt", 32'(err_cnt), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
